// File: rtl/mdu_iter_pkg.sv
// Shared op/state encodings and operand-class helpers for the iterative
// RV32M multiply/divide unit.
package mdu_iter_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  function automatic logic op_is_div(input mdu_op_e op);
    return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
  endfunction

  // MUL is run unsigned: the low half of the product is sign-agnostic.
  function automatic logic op_a_signed(input mdu_op_e op);
    return op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  endfunction

  function automatic logic op_b_signed(input mdu_op_e op);
    return op inside {MDU_MULH, MDU_DIV, MDU_REM};
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and shift the quotient bit in at the LSB.
module mdu_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quot_next
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             fits;

  always_comb begin
    shifted   = {rem, quot[WIDTH-1]};
    diff      = shifted - {2'b00, divisor};
    fits      = ~diff[WIDTH+1];
    rem_next  = fits ? diff[WIDTH:0] : shifted[WIDTH:0];
    quot_next = {quot[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, sign fix-up in a final cycle.
module mdu_iter #(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result
);

  import mdu_iter_pkg::*;

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  mdu_op_e            op_q;
  logic               neg_q;
  logic               neg_rem_q;
  logic               div0_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH:0]     rem_q;
  logic [WIDTH-1:0]   quot_q;
  logic [WIDTH-1:0]   result_q;

  mdu_op_e            in_op_e;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               accept;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_next;
  logic [WIDTH-1:0]   quot_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, result;

  assign in_ready   = (state_q == MDU_IDLE) || ((state_q == MDU_DONE) && out_ready);
  assign accept     = in_valid && in_ready && !flush;
  assign out_valid  = (state_q == MDU_DONE);
  assign out_result = result_q;

  always_comb begin
    in_op_e = mdu_op_e'(in_op);
    a_neg   = op_a_signed(in_op_e) && in_a[WIDTH-1];
    b_neg   = op_b_signed(in_op_e) && in_b[WIDTH-1];
    a_mag   = a_neg ? -in_a : in_a;
    b_mag   = b_neg ? -in_b : in_b;
  end

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem       (rem_q),
    .quot      (quot_q),
    .divisor   (opnd_q),
    .rem_next  (rem_next),
    .quot_next (quot_next)
  );

  // Multiplier bits are consumed from prod_q[0]; partial sum enters at the top.
  assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);

  // Divide-by-zero quotient is forced; the remainder path already yields |a|.
  always_comb begin
    prod_fix = neg_q ? -prod_q : prod_q;
    quot_fix = div0_q ? '1 : (neg_q ? -quot_q : quot_q);
    rem_fix  = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    case (op_q)
      MDU_MUL:                          result = prod_fix[WIDTH-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU:  result = prod_fix[2*WIDTH-1:WIDTH];
      MDU_DIV, MDU_DIVU:                result = quot_fix;
      MDU_REM, MDU_REMU:                result = rem_fix;
      default:                          result = prod_fix[WIDTH-1:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MDU_IDLE: if (accept) state_d = MDU_CALC;
      MDU_CALC: if (cnt_q == CNT_W'(1)) state_d = MDU_FIX;
      MDU_FIX:  state_d = MDU_DONE;
      MDU_DONE: if (out_ready) state_d = accept ? MDU_CALC : MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase
    if (flush) state_d = MDU_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MDU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      op_q      <= MDU_MUL;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      opnd_q    <= '0;
      prod_q    <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      result_q  <= '0;
    end else if (accept) begin
      cnt_q     <= CNT_W'(WIDTH);
      op_q      <= in_op_e;
      neg_q     <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      div0_q    <= (in_b == '0);
      opnd_q    <= op_is_div(in_op_e) ? b_mag : a_mag;
      prod_q    <= {{WIDTH{1'b0}}, b_mag};
      rem_q     <= '0;
      quot_q    <= a_mag;
    end else if (state_q == MDU_CALC) begin
      cnt_q  <= cnt_q - CNT_W'(1);
      prod_q <= {mul_sum, prod_q[WIDTH-1:1]};
      rem_q  <= rem_next;
      quot_q <= quot_next;
    end else if ((state_q == MDU_FIX) && !flush) begin
      result_q <= result;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: driver pushes expected results, a monitor
// checks latency, hold stability and result on each output handshake.
module tb_mdu_iter;

  import mdu_iter_pkg::*;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = W + 1;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;

  mdu_iter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  typedef struct {
    logic [31:0] res;
    int unsigned k;
    logic [2:0]  op;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } dir_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          bp_mode = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    case (bp_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RV32M semantics computed with wide integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    p  = '0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Must be called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    bit done = 0;
    int tries = 0;
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    while (!done && tries < 500) begin
      #1;
      if (in_ready && !flush && !rst) begin
        sb_q.push_back('{res: exp, k: cyc + 1, op: op});
        done = 1;
      end
      @(negedge clk);
      tries++;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL issue_timeout: op %0d never accepted", op);
    end
  endtask

  task automatic drain();
    int waited = 0;
    while (sb_q.size() != 0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor
  logic        prev_valid = 1'b0;
  logic        prev_pop = 1'b0;
  logic [31:0] prev_result = '0;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      prev_valid = 1'b0;
      prev_pop   = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (sb_q.size() == 0) check("spurious_out_valid", 32'd1, 32'd0);
        else check($sformatf("latency_op%0d", sb_q[0].op), 32'(cyc), 32'(sb_q[0].k + LAT));
      end
      if (out_valid && prev_valid && !prev_pop) begin
        check("hold_stable", out_result, prev_result);
        check("hold_in_ready", {31'b0, in_ready}, {31'b0, out_ready});
      end
      prev_pop = 1'b0;
      if (out_valid && out_ready && sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check($sformatf("result_op%0d", e.op), out_result, e.res);
        prev_pop = 1'b1;
      end
      prev_valid  = out_valid;
      prev_result = out_result;
    end
  end

  dir_t dir[] = '{
    '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
    '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
    '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF},
    '{3'd1, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF},
    '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
    '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
    '{3'd5, 32'd100,        32'd7,         32'd14},
    '{3'd7, 32'd100,        32'd7,         32'd2},
    '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF},
    '{3'd6, 32'd5,          32'd0,         32'd5},
    '{3'd4, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF},
    '{3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9},
    '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
    '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0}
  };

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int waited;
    logic [2:0]  op;
    logic [31:0] a, b;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    repeat (3) @(negedge clk);
    #3;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_out_result", out_result, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    foreach (dir[i]) issue(dir[i].op, dir[i].a, dir[i].b, dir[i].exp);
    drain();

    // Backpressure: hold the result, then hand over back-to-back.
    bp_mode = 2;
    @(negedge clk);
    issue(3'd0, 32'd123, 32'd456, 32'd56088);
    waited = 0;
    while (!out_valid && waited < 100) begin
      @(negedge clk); #3; waited++;
    end
    check("bp_out_valid_seen", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #3;
      check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      check("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    @(posedge clk);
    bp_mode = 0;
    @(negedge clk);
    issue(3'd5, 32'd9, 32'd3, 32'd3);
    drain();

    // Flush on the 10th CALC cycle.
    issue(3'd0, 32'd11, 32'd13, 32'd143);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    sb_q.delete();
    @(negedge clk);
    flush = 1'b0;
    #3;
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    repeat (40) @(negedge clk);

    // Reset mid-CALC.
    issue(3'd4, 32'd1000, 32'd10, 32'd100);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #3;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    repeat (40) @(negedge clk);
    issue(3'd0, 32'd6, 32'd7, 32'd42);
    drain();

    // Randomized ops against the reference model, with random backpressure.
    bp_mode = 1;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      issue(op, a, b, ref_model(op, a, b));
    end
    @(posedge clk);
    bp_mode = 0;
    drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised, multi-cycle RV32M multiply/divide unit.
- Sits beside the single-cycle ALU in the execute stage and handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Iterative: radix-2 shift-add multiply and restoring divide, one bit per cycle.
- valid/ready handshake on input and output so the pipeline can stall on it; a flush input kills an in-flight op.

Parameters:
- WIDTH, 32, operand/result width in bits; must be even and ≥ 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  abort the current op; no result is produced
- in_valid  input  1  operands and op are valid
- in_ready  output  1  unit can accept an op this cycle
- in_op  input  3  `MDU_* encoding
- in_a  input  WIDTH  rs1 operand
- in_b  input  WIDTH  rs2 operand
- out_valid  output  1  result is valid and held
- out_ready  input  1  consumer takes the result this cycle
- out_result  output  WIDTH  result

Behaviour:
- Reset: synchronous, active-high, at the rising edge of clk.
  - State goes to IDLE, counter to 0, out_valid=0, out_result=0, in_ready=1 from the next cycle.
  - Reset mid-operation discards all state.
- States: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1. The edge where in_valid&&in_ready holds captures op and operands, then goes to CALC with counter=WIDTH.
  - Signed ops store operand magnitudes plus the result-sign flags.
  - MULHSU treats in_a as signed and in_b as unsigned.
- CALC: one iteration per cycle; counter decrements; goes to FIX when counter reaches 1.
  - Multiply: 2*WIDTH-bit product register, shift-add.
  - Divide: restoring; remainder register WIDTH+1 bits; quotient shifted in LSB-first.
- FIX: applies two's-complement sign correction, selects the result, registers out_result, then goes to DONE.
  - MUL returns the low WIDTH bits.
  - MULH/MULHSU/MULHU return the high WIDTH bits.
  - REM takes the sign of the dividend.
- Latency: accept at edge k gives out_valid=1 after edge k+WIDTH+1. It is fixed for all ops and data, including the special cases.
- DONE: out_valid=1; out_result is stable until handshake.
  - out_ready=1 with in_valid=0: goes to IDLE.
  - out_ready=1 with in_valid=1: back-to-back, in_ready=1 in DONE when out_ready=1; the new op is captured and the state goes to CALC.
  - out_ready=0: holds in DONE; in_ready=0.
- in_ready is combinational from state and out_ready only. No input-to-output combinational path.
- Divide by zero (in_b=0):
  - DIV/DIVU quotient = all ones.
  - REM/REMU remainder = in_a.
  - Flagged at accept; still fixed latency.
- Signed overflow (in_a=MIN, in_b=-1):
  - DIV = MIN.
  - REM = 0.
- flush: synchronous.
  - In CALC, FIX or DONE: goes to IDLE next edge, out_valid=0.
  - In IDLE: no acceptance that cycle even if in_valid=1; in_ready is still reported as 1, but the handshake is ignored.
  - rst has priority over flush.
- Undefined in_op codes: execute as MUL.

Decomposition:
- control_signals.vh gains:
  - `MDU_MUL=0, `MDU_MULH=1, `MDU_MULHSU=2, `MDU_MULHU=3, `MDU_DIV=4, `MDU_DIVU=5, `MDU_REM=6, `MDU_REMU=7.
  - State encodings `MDU_IDLE/CALC/FIX/DONE.
- One sub-module: mdu_div_step.
  - Combinational single restoring-division step.
  - Inputs: rem, quot, divisor. Outputs: next rem, next quot.
  - Reused for unit-testing the datapath.
- Multiply step and FSM stay in mdu_iter.

Test Plan:
- MUL 7 × -3 (WIDTH=32) → out_result=0xFFFFFFEB, out_valid exactly 33 cycles after accept.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0. All with 33-cycle latency.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE → result stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 (DIVU 9/3) → second op accepted the same edge, result 3 after 33 cycles.
- flush at cycle 10 of CALC, and rst asserted mid-CALC → out_valid never rises for that op, in_ready=1 next cycle; a following MUL 6×7 returns 42.
